// File: rtl/circ_smpl_queue_if.sv
// Sample-queue bus: write strobe/data towards the queue, replay stream and status flags back.
interface circ_smpl_queue_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned CH = 2
);
  logic               wrt_smpl;
  logic [CH*DW-1:0]   smpl_in;
  logic [CH*DW-1:0]   smpl_out;
  logic               smpl_vld;
  logic               sequencing;
  logic               full;
  logic               ovf;

  modport master (
    output wrt_smpl, smpl_in,
    input  smpl_out, smpl_vld, sequencing, full, ovf
  );

  modport slave (
    input  wrt_smpl, smpl_in,
    output smpl_out, smpl_vld, sequencing, full, ovf
  );
endinterface

// File: rtl/circ_smpl_queue.sv
// Multi-channel circular sample queue: once SEQ_LEN samples are held, every write replays the
// newest SEQ_LEN samples oldest-first. Optional overrun detection under CIRC_Q_OVF_DETECT_EN.
module circ_smpl_queue #(
  parameter int unsigned DW      = 16,
  parameter int unsigned CH      = 2,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned SEQ_LEN = 1021
) (
  input  logic              clk,
  input  logic              rst_n,
  circ_smpl_queue_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(SEQ_LEN + 1);
  localparam int unsigned SW = CH * DW;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEQ  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [SW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   w_wr_ptr_nxt;
  logic [AW-1:0]   w_rd_ptr_nxt;
  logic [CW-1:0]   r_fill_cnt;
  logic [CW-1:0]   r_rd_cnt;
  logic [CW-1:0]   w_fill_cnt_nxt;
  logic [CW-1:0]   w_rd_cnt_nxt;
  logic            r_pend;
  logic            w_pend_nxt;
  logic            w_issue;
  logic            w_full_nxt;
  logic            r_vld;
  logic            r_seq;
  logic            r_full;
  logic [SW-1:0]   r_dout;

  // Next-state, pointer and pending-trigger logic
  always_comb begin
    w_state_nxt    = r_state;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_pend_nxt     = r_pend;
    w_issue        = 1'b0;
    w_wr_ptr_nxt   = r_wr_ptr + AW'(bus.wrt_smpl);
    w_fill_cnt_nxt = r_fill_cnt;
    if (bus.wrt_smpl && (r_fill_cnt != CW'(SEQ_LEN))) begin
      w_fill_cnt_nxt = r_fill_cnt + CW'(1);
    end
    w_full_nxt = (w_fill_cnt_nxt == CW'(SEQ_LEN));

    case (r_state)
      ST_IDLE: begin
        // Start point chosen so the burst ends on the newest sample, this cycle's write included
        if ((bus.wrt_smpl && w_full_nxt) || r_pend) begin
          w_state_nxt  = ST_SEQ;
          w_rd_ptr_nxt = w_wr_ptr_nxt - AW'(SEQ_LEN);
          w_rd_cnt_nxt = '0;
          w_pend_nxt   = 1'b0;
        end
      end
      ST_SEQ: begin
        w_issue      = 1'b1;
        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
        w_rd_cnt_nxt = r_rd_cnt + CW'(1);
        if (bus.wrt_smpl) begin
          w_pend_nxt = 1'b1;
        end
        if (r_rd_cnt == CW'(SEQ_LEN - 1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill_cnt <= '0;
      r_rd_cnt   <= '0;
      r_pend     <= 1'b0;
      r_vld      <= 1'b0;
      r_seq      <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_fill_cnt <= w_fill_cnt_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_pend     <= w_pend_nxt;
      r_vld      <= w_issue;
      // Covers the issue window plus the trailing valid cycle
      r_seq      <= (w_state_nxt == ST_SEQ) | w_issue;
      r_full     <= w_full_nxt;
    end
  end

  // Sample storage; not reset. Read and write addresses never collide since DEPTH >= SEQ_LEN+2
  always_ff @(posedge clk) begin
    if (bus.wrt_smpl) begin
      r_mem[r_wr_ptr] <= bus.smpl_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (w_issue) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign bus.smpl_out   = r_dout;
  assign bus.smpl_vld   = r_vld;
  assign bus.sequencing = r_seq;
  assign bus.full       = r_full;

`ifdef CIRC_Q_OVF_DETECT_EN
  logic       w_overrun;
  logic       r_ovf;
  logic [7:0] r_ovf_cnt;

  // A write while a re-trigger is already pending is an overrun
  assign w_overrun = bus.wrt_smpl & r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf     <= 1'b0;
      r_ovf_cnt <= '0;
    end else if (w_overrun) begin
      r_ovf <= 1'b1;
      if (r_ovf_cnt != 8'hFF) begin
        r_ovf_cnt <= r_ovf_cnt + 8'd1;
      end
    end
  end

  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_circ_smpl_queue.sv
// Randomised/directed bench for circ_smpl_queue against a burst-schedule reference model.
module tb_circ_smpl_queue;

  localparam int SEQ_LEN = 8;
  localparam int DEPTH   = 16;

  logic clk;
  logic rst_n;

  circ_smpl_queue_if #(.DW(16), .CH(2)) bus_a ();
  circ_smpl_queue_if #(.DW(12), .CH(4)) bus_b ();

  circ_smpl_queue #(.DW(16), .CH(2), .DEPTH(DEPTH), .SEQ_LEN(SEQ_LEN)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  circ_smpl_queue #(.DW(12), .CH(4), .DEPTH(DEPTH), .SEQ_LEN(SEQ_LEN)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: history of samples and a cycle-indexed schedule of expected outputs
  int          cyc;
  int          nwr;
  int          last_issue;
  bit          pend;
  bit          m_ovf;
  logic [31:0] hist_a[$];
  logic [47:0] hist_b[$];
  bit          exp_vld[int];
  bit          exp_seq[int];
  logic [31:0] exp_da[int];
  logic [47:0] exp_db[int];
  int          seq_cnt;
  int          vld_cnt;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic bit ovf_exp();
`ifdef CIRC_Q_OVF_DETECT_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    cyc        = 0;
    nwr        = 0;
    last_issue = -1;
    pend       = 1'b0;
    m_ovf      = 1'b0;
    hist_a.delete();
    hist_b.delete();
    exp_vld.delete();
    exp_seq.delete();
    exp_da.delete();
    exp_db.delete();
  endtask

  task automatic check_cycle();
    bit ev;
    ev = exp_vld.exists(cyc);
    if (bus_a.sequencing) seq_cnt++;
    if (bus_a.smpl_vld)   vld_cnt++;
    chk("vld_a",  64'(bus_a.smpl_vld),   64'(ev));
    chk("seq_a",  64'(bus_a.sequencing), 64'(exp_seq.exists(cyc)));
    chk("full_a", 64'(bus_a.full),       64'(nwr >= SEQ_LEN));
    chk("ovf_a",  64'(bus_a.ovf),        64'(ovf_exp()));
    chk("vld_b",  64'(bus_b.smpl_vld),   64'(ev));
    chk("seq_b",  64'(bus_b.sequencing), 64'(exp_seq.exists(cyc)));
    if (ev) begin
      chk("data_a", 64'(bus_a.smpl_out), 64'(exp_da[cyc]));
      chk("data_b", 64'(bus_b.smpl_out), 64'(exp_db[cyc]));
    end
  endtask

  // Drive one cycle of input, advance the model, then check the following cycle
  task automatic step(input bit w, input logic [31:0] da, input logic [47:0] db);
    bus_a.wrt_smpl = w;
    bus_a.smpl_in  = da;
    bus_b.wrt_smpl = w;
    bus_b.smpl_in  = db;
    if (w) begin
      hist_a.push_back(da);
      hist_b.push_back(db);
      nwr++;
      if (pend) m_ovf = 1'b1;
    end
    if (cyc <= last_issue) begin
      if (w) pend = 1'b1;
    end else if ((w && nwr >= SEQ_LEN) || pend) begin
      pend = 1'b0;
      for (int k = 0; k < SEQ_LEN; k++) begin
        int t;
        t = cyc + 2 + k;
        exp_vld[t]   = 1'b1;
        exp_seq[t-1] = 1'b1;
        exp_seq[t]   = 1'b1;
        exp_da[t]    = hist_a[hist_a.size() - SEQ_LEN + k];
        exp_db[t]    = hist_b[hist_b.size() - SEQ_LEN + k];
      end
      last_issue = cyc + SEQ_LEN;
    end
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 48'h0);
  endtask

  task automatic wr_idx(input int i);
    step(1'b1, {16'(i), 16'(i)}, {12'(i), 12'(i + 1), 12'(i + 2), 12'(i + 3)});
  endtask

  task automatic wr_rand();
    step(1'b1, 32'($urandom()), 48'({$urandom(), $urandom()}));
  endtask

  // Assert reset from a negedge; outputs must drop immediately
  task automatic apply_reset();
    rst_n          = 1'b0;
    bus_a.wrt_smpl = 1'b0;
    bus_b.wrt_smpl = 1'b0;
    bus_a.smpl_in  = '0;
    bus_b.smpl_in  = '0;
    #1;
    chk("rst_vld",  64'(bus_a.smpl_vld),   64'(0));
    chk("rst_seq",  64'(bus_a.sequencing), 64'(0));
    chk("rst_full", 64'(bus_a.full),       64'(0));
    chk("rst_ovf",  64'(bus_a.ovf),        64'(0));
    chk("rst_out",  64'(bus_a.smpl_out),   64'(0));
    chk("rst_vldb", 64'(bus_b.smpl_vld),   64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // Fill: seven writes hold off, the eighth triggers the first burst
    for (int i = 1; i <= 7; i++) begin
      wr_idx(i);
      idle(1);
    end
    chk("fill7_full", 64'(bus_a.full), 64'(0));
    seq_cnt = 0;
    vld_cnt = 0;
    wr_idx(8);
    chk("fill8_full", 64'(bus_a.full), 64'(1));
    idle(14);
    chk("burst_seq_cycles", 64'(seq_cnt), 64'(SEQ_LEN + 1));
    chk("burst_vld_pulses", 64'(vld_cnt), 64'(SEQ_LEN));

    // Wrap: 40 spaced writes, pointers wrap the 16-entry memory
    apply_reset();
    for (int i = 1; i <= 40; i++) begin
      wr_idx(i);
      idle(11);
    end

    // Pending: one write mid-burst re-triggers after the burst, no overrun
    wr_idx(100);
    idle(3);
    wr_idx(101);
    idle(25);
    chk("pend_ovf", 64'(bus_a.ovf), 64'(0));

    // Overrun: two writes in one burst
    wr_idx(200);
    idle(2);
    wr_idx(201);
    idle(2);
    wr_idx(202);
    idle(25);
`ifdef CIRC_Q_OVF_DETECT_EN
    chk("ovr_ovf", 64'(bus_a.ovf), 64'(1));
`else
    chk("ovr_ovf", 64'(bus_a.ovf), 64'(0));
`endif

    // Reset in the fourth burst cycle, then refill
    apply_reset();
    for (int i = 1; i <= 8; i++) begin
      wr_idx(300 + i);
      idle(1);
    end
    idle(20);
    wr_idx(400);
    idle(3);
    chk("mid_seq_before", 64'(bus_a.sequencing), 64'(1));
    apply_reset();
    for (int i = 1; i <= 7; i++) begin
      wr_idx(500 + i);
      idle(1);
    end
    chk("rst_refill_full", 64'(bus_a.full), 64'(0));
    vld_cnt = 0;
    wr_idx(508);
    idle(12);
    chk("rst_refill_burst", 64'(vld_cnt), 64'(SEQ_LEN));

    // Random traffic: exercises back-to-back bursts, pending and overrun
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(2) == 0) wr_rand();
      else idle(1);
    end
    idle(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
